// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared constants and helpers for the dmem_mmio data port
package dmem_mmio_pkg;

    localparam int REGION_BIT = 31;
    localparam int IO_IDX_W   = 10;
    localparam int BYTE_W     = 8;
    localparam int N_LANES    = 4;

    localparam logic [IO_IDX_W-1:0] IO_IN_BASE  = 10'd0;
    localparam logic [IO_IDX_W-1:0] IO_OUT_BASE = 10'd64;
    localparam logic [IO_IDX_W-1:0] IO_CHG      = 10'd128;
    localparam logic [IO_IDX_W-1:0] IO_CYCLES   = 10'd129;

    typedef enum logic {
        RD_IO  = 1'b0,
        RD_RAM = 1'b1
    } rd_src_e;

    function automatic logic [31:0] strb_mask(input logic [N_LANES-1:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < N_LANES; b++) begin
            m[b*BYTE_W +: BYTE_W] = {BYTE_W{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_in_sync.sv
// rtl/dmem_in_sync.sv - one input channel: synchroniser chain, change detect, sticky flag
module dmem_in_sync #(
    parameter int W      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         clr,
    output logic [W-1:0] dout,
    output logic         flag
);

    logic [STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]             prev_q, prev_d;
    logic                     flag_q, flag_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        flag_d = flag_q;
        if (clr) begin
            flag_d = 1'b0;
        end
        // a fresh change outranks a clearing read in the same cycle
        if (sync_q[STAGES-1] != prev_q) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            flag_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            flag_q <= flag_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign flag = flag_q;

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus memory-mapped I/O; DMEM_MMIO_BYTE_EN enables byte strobes
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int OPR_W       = 16,
    parameter int N_IN        = 1,
    parameter int N_OUT       = 1,
    parameter int RAM_DEPTH   = 16384,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   re,
    input  logic                   we,
    input  logic [3:0]             wstrb,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   rvalid,
    input  logic [N_IN*OPR_W-1:0]  opr_in,
    output logic [N_OUT*OPR_W-1:0] result_out,
    output logic [N_OUT-1:0]       result_stb
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic                is_io;
    logic [IO_IDX_W-1:0] io_idx;
    logic [RAM_AW-1:0]   ram_idx;
    logic [3:0]          eff_strb;
    logic [31:0]         wmask;
    logic                unused_in;

    assign is_io   = addr[REGION_BIT];
    assign io_idx  = addr[11:2];
    assign ram_idx = addr[RAM_AW+1:2];
    assign unused_in = ^{addr, wstrb};

`ifdef DMEM_MMIO_BYTE_EN
    assign eff_strb = wstrb;
`else
    assign eff_strb = 4'hF;
`endif
    assign wmask = strb_mask(eff_strb);

    // ---------------- input channels ----------------
    logic [N_IN-1:0][OPR_W-1:0] in_val;
    logic [N_IN-1:0]            chg_flag;
    logic [N_IN-1:0]            in_clr;

    always_comb begin
        in_clr = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_clr[i] = re && is_io && (io_idx == IO_IN_BASE + IO_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        dmem_in_sync #(
            .W      (OPR_W),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (opr_in[g*OPR_W +: OPR_W]),
            .clr  (in_clr[g]),
            .dout (in_val[g]),
            .flag (chg_flag[g])
        );
    end

    // ---------------- RAM (read-first, contents never reset) ----------------
    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] ram_dout;
    logic        ram_we, ram_re;

    assign ram_we = we && !is_io;
    assign ram_re = re && !is_io;

    always_ff @(posedge clk) begin
        for (int b = 0; b < N_LANES; b++) begin
            if (ram_we && eff_strb[b]) begin
                mem[ram_idx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
        end
        if (ram_re) begin
            ram_dout <= mem[ram_idx];
        end
    end

    // ---------------- I/O registers ----------------
    logic [N_OUT-1:0][OPR_W-1:0] result_q, result_d;
    logic [N_OUT-1:0]            stb_q, stb_d;
    logic [31:0]                 cycles_q, cycles_d;
    logic [31:0]                 io_rd_val;

    always_comb begin
        io_rd_val = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (io_idx == IO_IN_BASE + IO_IDX_W'(i)) io_rd_val = 32'(in_val[i]);
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (io_idx == IO_OUT_BASE + IO_IDX_W'(j)) io_rd_val = 32'(result_q[j]);
        end
        if (io_idx == IO_CHG)    io_rd_val = 32'(chg_flag);
        if (io_idx == IO_CYCLES) io_rd_val = cycles_q;
    end

    always_comb begin
        result_d = result_q;
        stb_d    = '0;
        cycles_d = cycles_q + 32'd1;
        for (int j = 0; j < N_OUT; j++) begin
            if (we && is_io && (io_idx == IO_OUT_BASE + IO_IDX_W'(j))) begin
                result_d[j] = (result_q[j] & ~wmask[OPR_W-1:0]) | (wdata[OPR_W-1:0] & wmask[OPR_W-1:0]);
                stb_d[j]    = 1'b1;
            end
        end
    end

    // ---------------- read response ----------------
    rd_src_e     rd_src_q, rd_src_d;
    logic [31:0] io_rdata_q, io_rdata_d;
    logic        rvalid_q, rvalid_d;

    always_comb begin
        rvalid_d   = re;
        rd_src_d   = rd_src_q;
        io_rdata_d = io_rdata_q;
        if (re) begin
            rd_src_d = is_io ? RD_IO : RD_RAM;
            if (is_io) io_rdata_d = io_rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            stb_q      <= '0;
            cycles_q   <= '0;
            rd_src_q   <= RD_IO;
            io_rdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            result_q   <= result_d;
            stb_q      <= stb_d;
            cycles_q   <= cycles_d;
            rd_src_q   <= rd_src_d;
            io_rdata_q <= io_rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // reset selects the zeroed I/O holding register, so rdata reads 0 without touching the RAM port
    assign rdata      = (rd_src_q == RD_RAM) ? ram_dout : io_rdata_q;
    assign rvalid     = rvalid_q;
    assign result_out = result_q;
    assign result_stb = stb_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - scoreboard bench for dmem_mmio
module tb_dmem_mmio;

    localparam int OPR_W = 16;
    localparam int N_IN  = 2;
    localparam int N_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [N_IN*OPR_W-1:0]  opr_in = '0;
    logic [N_OUT*OPR_W-1:0] result_out;
    logic [N_OUT-1:0]       result_stb;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];
    logic pend = 1'b0;
    logic mon_en = 1'b0;

    dmem_mmio #(
        .OPR_W       (OPR_W),
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .RAM_DEPTH   (256),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .we         (we),
        .wstrb      (wstrb),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .opr_in     (opr_in),
        .result_out (result_out),
        .result_stb (result_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) pend <= re && !rst;

    always @(negedge clk) begin
        if (mon_en) begin
            check("rvalid", 32'(rvalid), 32'(pend));
            if (rvalid) begin
                if (exp_q.size() == 0) check("rq_underflow", 32'(exp_q.size()), 32'd1);
                else check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        re = 1'b1; addr = a;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; addr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        re = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = 4'hF;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_byte, exp_out0;
`ifdef DMEM_MMIO_BYTE_EN
        exp_byte = 32'hAA22CC44;
        exp_out0 = 32'h000056EE;
`else
        exp_byte = 32'h11223344;
        exp_out0 = 32'h000099EE;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_result_out", result_out, 32'd0);
        check("rst_result_stb", 32'(result_stb), 32'd0);
        mon_en = 1'b1;

        // RAM write/read, read-first collision, byte strobes, wrap
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10, 32'hDEADBEEF);
        wr(32'h10, 32'h11111111, 4'hF);
        rw(32'h10, 32'h22222222, 32'h11111111);
        rd(32'h10, 32'h22222222);
        wr(32'h20, 32'hAABBCCDD, 4'hF);
        wr(32'h20, 32'h11223344, 4'b0101);
        rd(32'h20, exp_byte);
        wr(32'h400, 32'hCAFEF00D, 4'hF);
        rd(32'h0, 32'hCAFEF00D);
        rd(32'h10, 32'h22222222);

        // output channels
        wr(32'h80000104, 32'h1234ABCD, 4'hF);
        check("out_value", result_out, 32'hABCD0000);
        check("out_stb", 32'(result_stb), 32'h2);
        @(posedge clk); #1;
        check("out_stb_drop", 32'(result_stb), 32'h0);
        rd(32'h80000104, 32'h0000ABCD);
        wr(32'h80000100, 32'h00005678, 4'hF);
        check("out0_stb", 32'(result_stb), 32'h1);
        wr(32'h80000100, 32'hFFFF99EE, 4'b0001);
        rd(32'h80000100, exp_out0);
        rd(32'h80000104, 32'h0000ABCD);

        // unmapped I/O
        wr(32'h80000FFC, 32'hFFFFFFFF, 4'hF);
        rd(32'h80000FFC, 32'h0);
        rd(32'h80000008, 32'h0);
        rd(32'h80000108, 32'h0);

        // input change flags
        opr_in[15:0] = 16'h5A5A;
        repeat (4) @(posedge clk);
        #1;
        rd(32'h80000200, 32'h1);
        rd(32'h80000200, 32'h1);
        rd(32'h80000000, 32'h5A5A);
        rd(32'h80000200, 32'h0);
        opr_in[31:16] = 16'h0F0F;
        repeat (4) @(posedge clk);
        #1;
        rd(32'h80000200, 32'h2);
        rd(32'h80000004, 32'h0F0F);
        rd(32'h80000200, 32'h0);

        // change lands on the same edge as a clearing read: flag must survive
        opr_in[15:0] = 16'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd(32'h80000000, 32'h1234);
        rd(32'h80000200, 32'h1);
        rd(32'h80000000, 32'h1234);
        rd(32'h80000200, 32'h0);

        // reset right after a read
        rd(32'h10, 32'h22222222);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_result_out", result_out, 32'd0);
        rst = 1'b0;
        rd(32'h80000204, 32'd0);
        rd(32'h80000204, 32'd1);
        rd(32'h80000FFC, 32'h0);
        rd(32'h10, 32'h22222222);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
